uart_rx_os: RTL

Oversampling UART receiver (8N1, LSB first) that turns the serial `rx` line into bytes handed to the RX FIFO through a valid/ready handshake. It sits between the board `rx` pin and the FIFO write side of the loopback top, and is the receiving end of the serial stream the system bench drives at 9600 baud from a 100 MHz clock. It detects start bits, centres sampling with a 16× tick, and flags framing errors and overruns.

---
 rtl/uart_rx_os.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 oversampling UART receiver with valid/ready byte output (optional UART_RX_MAJORITY_EN 2-of-3 bit voting)
module uart_rx_os #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVS);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // decision ticks sit one tick later when voting so the mid+1 sample is available
  localparam logic [TW-1:0] C_MS = TW'(OVS / 2 - 1 + MAJ);
  localparam logic [TW-1:0] C_MD = TW'(OVS - 1 + MAJ);
  localparam logic [TW-1:0] C_TS = TW'(MAJ);
  localparam logic [DW-1:0] C_DL = DW'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          r_state, w_next;
  logic            r_rx_meta, r_rxs;
  logic [DW-1:0]   r_div;
  logic [TW-1:0]   r_tcnt;
  logic [2:0]      r_bcnt;
  logic [7:0]      r_shreg;
  logic            w_tick, w_bit, w_ms, w_md;
  logic            w_clr, w_tset, w_shift, w_deliver, w_ferr;

  assign w_tick = r_div == C_DL;
  assign w_ms   = w_tick && r_tcnt == C_MS;
  assign w_md   = w_tick && r_tcnt == C_MD;
  assign busy   = r_state != S_IDLE;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_smp;
  // keep the two previous tick samples for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_smp <= 2'b11;
    else if (w_tick) r_smp <= {r_smp[0], r_rxs};
  end
  assign w_bit = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rxs) | (r_smp[0] & r_rxs);
`else
  assign w_bit = r_rxs;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // next state and per-cycle control strobes
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_tset    = 1'b0;
    w_shift   = 1'b0;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr  = !r_rxs;
        w_next = r_rxs ? S_IDLE : S_START;
      end
      S_START: if (w_ms) begin
        w_tset = !w_bit;
        w_next = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_md) begin
        w_shift = 1'b1;
        w_next  = (r_bcnt == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (w_md) begin
        w_deliver = w_bit;
        w_ferr    = !w_bit;
        w_next    = w_bit ? S_IDLE : S_BREAK;
      end
      S_BREAK: w_next = r_rxs ? S_IDLE : S_BREAK;
      default: w_next = S_IDLE;
    endcase
  end

  // synchronizer, tick divider, tick/bit counters and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_div     <= '0;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_shreg   <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_div     <= (w_clr || w_tick) ? '0 : r_div + 1'b1;
      r_tcnt    <= w_clr ? '0 : w_tset ? C_TS : w_tick ? r_tcnt + 1'b1 : r_tcnt;
      r_bcnt    <= w_tset ? 3'd0 : w_shift ? r_bcnt + 3'd1 : r_bcnt;
      r_shreg   <= w_shift ? {w_bit, r_shreg[7:1]} : r_shreg;
    end
  end

  // output handshake: a new byte loads unless the old one is still unaccepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= w_ferr;
      overrun   <= w_deliver && rx_valid && !rx_ready;
    end
  end
endmodule
